// File: rtl/piece_bag.sv
// piece_bag: LFSR-shuffled bag of NUM_TYPES piece IDs,
// filled by rejection sampling and dealt over valid/ready.
module piece_bag #(
  parameter int          NUM_TYPES   = 7,
  parameter int          PIECE_W     = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter bit          AUTO_REFILL = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         newbag,
  input  logic                         seed_load,
  input  logic [15:0]                  seed,
  input  logic                         piece_ready,
  output logic                         piece_valid,
  output logic [PIECE_W-1:0]           piece,
  output logic [$clog2(NUM_TYPES+1)-1:0] remaining,
  output logic [NUM_TYPES*PIECE_W-1:0] bag,
  output logic [NUM_TYPES-1:0]         bagflags,
  output logic                         filling,
  output logic [7:0]                   bag_count
);

  localparam int CW = $clog2(NUM_TYPES+1);

  typedef enum logic [1:0] {FILL, DEAL, EMPTY} state_t;

  state_t               state;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_nxt;
  logic [CW-1:0]        fill_idx;
  logic [CW-1:0]        rd_idx;
  logic [PIECE_W-1:0]   slot [NUM_TYPES];
  logic [PIECE_W-1:0]   cand;
  logic [PIECE_W-1:0]   last_t;
  logic [PIECE_W-1:0]   next_piece;
  logic [NUM_TYPES-1:0] cand_mask;
  logic [NUM_TYPES-1:0] last_mask;
  logic                 in_range;
  logic                 accept;
  logic                 last_slot;
  logic                 hs;
  logic                 last_hs;

  assign cand      = lfsr[PIECE_W-1:0];
  assign in_range  = {1'b0, cand} < (PIECE_W+1)'(NUM_TYPES);
  assign cand_mask = NUM_TYPES'(1) << cand;
  assign accept    = in_range && ((bagflags & cand_mask) == '0);
  assign last_mask = NUM_TYPES'(1) << last_t;
  assign last_slot = fill_idx == CW'(NUM_TYPES-1);
  assign hs        = piece_valid & piece_ready;
  assign last_hs   = hs && (rd_idx == CW'(NUM_TYPES-1));

  // Fibonacci taps 16,14,13,11; a zero seed falls back to SEED
  assign lfsr_nxt = seed_load ? ((seed != 16'd0) ? seed : SEED)
                  : {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    last_t = '0;
    for (int t = NUM_TYPES-1; t >= 0; t--)
      if (!bagflags[t]) last_t = PIECE_W'(t);
  end

  always_comb begin
    next_piece = '0;
    for (int i = 0; i < NUM_TYPES; i++)
      if (rd_idx + CW'(1) == CW'(i)) next_piece = slot[i];
  end

  always_comb begin
    bag = '0;
    for (int i = 0; i < NUM_TYPES; i++)
      bag[i*PIECE_W +: PIECE_W] = slot[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      lfsr        <= SEED;
      fill_idx    <= '0;
      rd_idx      <= '0;
      bagflags    <= '0;
      for (int i = 0; i < NUM_TYPES; i++) slot[i] <= '0;
      piece_valid <= 1'b0;
      piece       <= '0;
      remaining   <= '0;
      filling     <= 1'b1;
      bag_count   <= '0;
    end else begin
      lfsr <= lfsr_nxt;
      if (last_hs && !newbag) bag_count <= bag_count + 8'd1;
      if (newbag || (last_hs && AUTO_REFILL)) begin
        state       <= FILL;
        fill_idx    <= '0;
        rd_idx      <= '0;
        bagflags    <= '0;
        for (int i = 0; i < NUM_TYPES; i++) slot[i] <= '0;
        piece_valid <= 1'b0;
        piece       <= '0;
        remaining   <= '0;
        filling     <= 1'b1;
      end else begin
        case (state)
          FILL: begin
            if (last_slot) begin
              slot[NUM_TYPES-1] <= last_t;
              bagflags    <= bagflags | last_mask;
              state       <= DEAL;
              rd_idx      <= '0;
              piece_valid <= 1'b1;
              piece       <= slot[0];
              remaining   <= CW'(NUM_TYPES);
              filling     <= 1'b0;
            end else if (!seed_load && accept) begin
              for (int i = 0; i < NUM_TYPES; i++)
                if (fill_idx == CW'(i)) slot[i] <= cand;
              bagflags <= bagflags | cand_mask;
              fill_idx <= fill_idx + CW'(1);
            end
          end
          DEAL: begin
            if (last_hs) begin
              state       <= EMPTY;
              piece_valid <= 1'b0;
              piece       <= '0;
              remaining   <= '0;
            end else if (hs) begin
              rd_idx    <= rd_idx + CW'(1);
              piece     <= next_piece;
              remaining <= remaining - CW'(1);
            end
          end
          EMPTY: ;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piece_bag.sv
// tb_piece_bag: vector table, scoreboard queues and
// hand sequences over three piece_bag configurations.
module tb_piece_bag;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst = 3'b111;
  logic [2:0]       nb  = '0;
  logic [2:0]       rdy = '0;
  logic             sl  = 1'b0;
  logic [15:0]      seed = '0;
  logic [2:0]       vld;
  logic [2:0]       fil;
  logic [2:0][2:0]  pc;
  logic [2:0][2:0]  rem;
  logic [2:0][7:0]  bc;
  logic [20:0]      bag0, bag1;
  logic [14:0]      bag2;
  logic [6:0]       bf0, bf1;
  logic [4:0]       bf2;

  int checks = 0;
  int errors = 0;

  piece_bag u0 (
    .clk(clk), .reset(rst[0]), .newbag(nb[0]),
    .seed_load(sl), .seed(seed), .piece_ready(rdy[0]),
    .piece_valid(vld[0]), .piece(pc[0]), .remaining(rem[0]),
    .bag(bag0), .bagflags(bf0), .filling(fil[0]),
    .bag_count(bc[0]));

  piece_bag #(.AUTO_REFILL(1'b0)) u1 (
    .clk(clk), .reset(rst[1]), .newbag(nb[1]),
    .seed_load(1'b0), .seed(seed), .piece_ready(rdy[1]),
    .piece_valid(vld[1]), .piece(pc[1]), .remaining(rem[1]),
    .bag(bag1), .bagflags(bf1), .filling(fil[1]),
    .bag_count(bc[1]));

  piece_bag #(.NUM_TYPES(5), .PIECE_W(3)) u2 (
    .clk(clk), .reset(rst[2]), .newbag(nb[2]),
    .seed_load(1'b0), .seed(seed), .piece_ready(rdy[2]),
    .piece_valid(vld[2]), .piece(pc[2]), .remaining(rem[2]),
    .bag(bag2), .bagflags(bf2), .filling(fil[2]),
    .bag_count(bc[2]));

  typedef struct {
    logic [2:0] exp_rem;
    logic [6:0] exp_flags;
  } vec_t;

  vec_t vecs [7];
  logic [2:0] ref_q[$];
  logic [2:0] a_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(int u, output int n);
    n = 0;
    while (!vld[u] && n < 400) begin
      step();
      n++;
    end
    if (!vld[u]) begin
      checks++;
      errors++;
      $display("FAIL timeout u%0d: got valid 0 want 1", u);
    end
  endtask

  task automatic get(int u, output logic [2:0] p);
    int n;
    wait_valid(u, n);
    p = pc[u];
    step();
  endtask

  initial begin
    logic [2:0] p;
    logic [7:0] seen;
    logic [7:0] bc_save;
    int n;

    for (int i = 0; i < 7; i++)
      vecs[i] = '{exp_rem: 3'(7 - i), exp_flags: 7'h7F};

    // reset values
    step(); step();
    chk("rst_valid", 32'(vld[0]), 0);
    chk("rst_piece", 32'(pc[0]), 0);
    chk("rst_rem", 32'(rem[0]), 0);
    chk("rst_bag", 32'(bag0), 0);
    chk("rst_flags", 32'(bf0), 0);
    chk("rst_filling", 32'(fil[0]), 1);
    chk("rst_count", 32'(bc[0]), 0);
    rst[0] = 1'b0;
    rdy[0] = 1'b1;

    // first bag, table driven
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      wait_valid(0, n);
      chk("deal_rem", 32'(rem[0]), 32'(vecs[i].exp_rem));
      chk("deal_flags", 32'(bf0), 32'(vecs[i].exp_flags));
      p = pc[0];
      ref_q.push_back(p);
      seen |= 8'(1) << p;
      step();
    end
    chk("perm1", 32'(seen), 32'h7F);
    chk("count1", 32'(bc[0]), 1);
    chk("refill", 32'(fil[0]), 1);

    // second bag; fill latency
    wait_valid(0, n);
    chk("latency", 32'(n >= 7), 1);
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      get(0, p);
      ref_q.push_back(p);
      seen |= 8'(1) << p;
    end
    chk("perm2", 32'(seen), 32'h7F);
    chk("count2", 32'(bc[0]), 2);

    // backpressure
    rdy[0] = 1'b0;
    wait_valid(0, n);
    p = pc[0];
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_piece", 32'(pc[0]), 32'(p));
      chk("bp_rem", 32'(rem[0]), 7);
      chk("bp_valid", 32'(vld[0]), 1);
    end
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    chk("bp_pulse_rem", 32'(rem[0]), 6);
    chk("bp_pulse_valid", 32'(vld[0]), 1);

    // newbag after 3 handshakes
    rdy[0] = 1'b1;
    get(0, p);
    get(0, p);
    chk("nb_rem", 32'(rem[0]), 4);
    bc_save = bc[0];
    nb[0] = 1'b1;
    step();
    nb[0] = 1'b0;
    chk("nb_valid", 32'(vld[0]), 0);
    chk("nb_filling", 32'(fil[0]), 1);
    chk("nb_flags", 32'(bf0), 0);
    chk("nb_bag", 32'(bag0), 0);
    chk("nb_count", 32'(bc[0]), 32'(bc_save));
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      get(0, p);
      seen |= 8'(1) << p;
    end
    chk("nb_perm", 32'(seen), 32'h7F);
    chk("nb_count2", 32'(bc[0]), 32'(bc_save + 8'd1));

    // seed determinism: 1234 twice, then 0 vs reset run
    for (int r = 0; r < 3; r++) begin
      seed = (r == 2) ? 16'h0000 : 16'h1234;
      sl = 1'b1;
      nb[0] = 1'b1;
      step();
      sl = 1'b0;
      nb[0] = 1'b0;
      for (int i = 0; i < 14; i++) begin
        get(0, p);
        if (r == 0) a_q.push_back(p);
        else if (r == 1) chk("seed_rep", 32'(p), 32'(a_q.pop_front()));
        else chk("seed_zero", 32'(p), 32'(ref_q.pop_front()));
      end
    end

    // reset mid-DEAL
    rdy[0] = 1'b0;
    wait_valid(0, n);
    rst[0] = 1'b1;
    step();
    chk("mrst_valid", 32'(vld[0]), 0);
    chk("mrst_rem", 32'(rem[0]), 0);
    chk("mrst_bag", 32'(bag0), 0);
    chk("mrst_flags", 32'(bf0), 0);
    chk("mrst_filling", 32'(fil[0]), 1);
    chk("mrst_count", 32'(bc[0]), 0);

    // AUTO_REFILL = 0
    rst[1] = 1'b0;
    rdy[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      seen = '0;
      for (int i = 0; i < 7; i++) begin
        get(1, p);
        seen |= 8'(1) << p;
      end
      chk("nr_perm", 32'(seen), 32'h7F);
      chk("nr_count", 32'(bc[1]), 32'(b + 1));
      if (b == 0) begin
        for (int i = 0; i < 50; i++) begin
          chk("nr_valid", 32'(vld[1]), 0);
          chk("nr_filling", 32'(fil[1]), 0);
          chk("nr_rem", 32'(rem[1]), 0);
          step();
        end
        nb[1] = 1'b1;
        step();
        nb[1] = 1'b0;
        chk("nr_refill", 32'(fil[1]), 1);
      end
    end

    // NUM_TYPES = 5, 100 bags
    rst[2] = 1'b0;
    rdy[2] = 1'b1;
    for (int b = 0; b < 100; b++) begin
      seen = '0;
      for (int i = 0; i < 5; i++) begin
        wait_valid(2, n);
        chk("n5_flags", 32'(bf2), 32'h1F);
        chk("n5_range", 32'(pc[2] < 3'd5), 1);
        seen |= 8'(1) << pc[2];
        step();
      end
      chk("n5_perm", 32'(seen), 32'h1F);
    end
    chk("n5_count", 32'(bc[2]), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
